bcd_to_xs3_serial: RTL

BCD_TO_XS3_SERIAL -- requirements
Module: bcd_to_xs3_serial

---
 rtl/xs3_pkg.sv | 20 ++
 rtl/bcd_digit_to_xs3.sv | 14 +
 rtl/bcd_to_xs3_serial.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/xs3_pkg.sv
// Shared types and constants for the serial BCD to Excess-3 converter.
// The state enum, default digit count and Excess-3 offset live here so the top and the digit cell agree.
package xs3_pkg;

   localparam int         NDIG_DEFAULT = 4;
   localparam logic [3:0] XS3_OFFSET   = 4'd3;
   localparam logic [3:0] BCD_MAX      = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index counter width; a single-digit build still needs a 1-bit index.
   function automatic int idx_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/bcd_digit_to_xs3.sv
// Combinational single-digit converter: Excess-3 = BCD + 3 (mod 16).
// The invalid flag marks a nibble outside the BCD range 0..9.
module bcd_digit_to_xs3
   import xs3_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [3:0] xs3,
   output logic       invalid
);

   assign xs3     = bcd + XS3_OFFSET;
   assign invalid = (bcd > BCD_MAX);

endmodule

// File: rtl/bcd_to_xs3_serial.sv
// Serial BCD to Excess-3 word converter: one digit per cycle, valid/ready on both sides.
// Optional macro XS3_ERR_CHECK_EN enables the sticky out_err flag for non-BCD digits.
module bcd_to_xs3_serial
   import xs3_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [4*NDIG-1:0] in_bcd,
   output logic              in_ready,
   output logic              out_valid,
   output logic [4*NDIG-1:0] out_xs3,
   output logic              out_err,
   input  logic              out_ready
);

   localparam int IDX_W = idx_width(NDIG);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

   state_t state_reg, state_next;

   logic [IDX_W-1:0]  idx_reg;
   logic [4*NDIG-1:0] bcd_reg;
   logic [4*NDIG-1:0] work_reg;
   logic [4*NDIG-1:0] work_next;
   logic [4*NDIG-1:0] out_xs3_reg;

   logic [3:0] bcd_digit [NDIG];
   logic [3:0] cur_bcd;
   logic [3:0] cur_xs3;
   logic       digit_invalid;
   logic       last_digit;

   // Split the captured word into digits so the current one can be selected by index.
   for (genvar gi = 0; gi < NDIG; gi++) begin : g_split
      assign bcd_digit[gi] = bcd_reg[4*gi +: 4];
   end

   assign cur_bcd    = bcd_digit[idx_reg];
   assign last_digit = (idx_reg == LAST_IDX);

   bcd_digit_to_xs3 u_digit (
      .bcd     (cur_bcd),
      .xs3     (cur_xs3),
      .invalid (digit_invalid)
   );

   // Working word: only the digit under the index is replaced this cycle.
   for (genvar gi = 0; gi < NDIG; gi++) begin : g_merge
      assign work_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? cur_xs3 : work_reg[4*gi +: 4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = CONV;
            end
         end
         CONV: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The published word only changes on the final conversion edge, so out_xs3
   // keeps its previous value through IDLE and CONV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg     <= '0;
         bcd_reg     <= '0;
         work_reg    <= '0;
         out_xs3_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  bcd_reg <= in_bcd;
                  idx_reg <= '0;
               end
            end
            CONV: begin
               work_reg <= work_next;
               if (last_digit) begin
                  idx_reg     <= '0;
                  out_xs3_reg <= work_next;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_xs3 = out_xs3_reg;

`ifdef XS3_ERR_CHECK_EN
   logic err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (state_reg == IDLE && in_valid) begin
         err_reg <= 1'b0;
      end else if (state_reg == CONV) begin
         err_reg <= err_reg | digit_invalid;
      end
   end

   assign out_err = err_reg;
`else
   logic unused_invalid;

   assign unused_invalid = digit_invalid;
   assign out_err        = 1'b0;
`endif

endmodule
